// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: control-unit <-> multiply/divide unit handshake and HI/LO bus.
// MDU_MTHILO_EN adds the hilo_we/hilo_wdata direct-write lines.
interface mult_div_unit_if #(parameter int WIDTH = 16);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;
`ifdef MDU_MTHILO_EN
  logic [1:0]       hilo_we;
  logic [WIDTH-1:0] hilo_wdata;
`endif
  modport master(
    output start, op, src_a, src_b, flush,
`ifdef MDU_MTHILO_EN
    output hilo_we, hilo_wdata,
`endif
    input busy, done, hi, lo, div_by_zero
  );
  modport slave(
    input start, op, src_a, src_b, flush,
`ifdef MDU_MTHILO_EN
    input hilo_we, hilo_wdata,
`endif
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MULT/MULTU/DIV/DIVU (shift-add / restoring divide) into HI/LO.
// MDU_MTHILO_EN enables direct HI/LO writes while idle.
module mult_div_unit #(
  parameter int WIDTH = 16
) (
  input logic            clk,
  input logic            rst_n,
  mult_div_unit_if.slave m
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nx;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_r;
  logic               sa, sb, bz;
  logic [WIDTH-1:0]   a_raw, d, q;
  logic [WIDTH:0]     r;
  logic               accept, busy_nx, done_nx, sa_in, sb_in, dneg;
  logic [WIDTH-1:0]   mag_a, mag_b, quo, rem, res_hi, res_lo;
  logic [WIDTH:0]     msum, dsh, dsub;
  logic [2*WIDTH-1:0] prod, prod_s;
  assign accept = state == IDLE && m.start && !m.flush;
  assign sa_in  = m.op[0] & m.src_a[WIDTH-1];
  assign sb_in  = m.op[0] & m.src_b[WIDTH-1];
  assign mag_a  = sa_in ? -m.src_a : m.src_a;
  assign mag_b  = sb_in ? -m.src_b : m.src_b;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb
    state_nx = m.flush       ? IDLE :
               state == IDLE ? (accept ? CALC : IDLE) :
               state == CALC ? (cnt == CW'(WIDTH - 1) ? FIX : CALC) :
                               IDLE;
  always_comb begin
    busy_nx = state_nx != IDLE;
    done_nx = state == FIX && !m.flush;
  end
  // r:q is the running {partial product, multiplier} or {remainder, dividend}
  assign msum = {1'b0, r[WIDTH-1:0]} + (q[0] ? {1'b0, d} : '0);
  assign dsh  = {r[WIDTH-1:0], q[WIDTH-1]};
  assign dsub = dsh - {1'b0, d};
  assign dneg = dsh < {1'b0, d};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_r  <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      bz    <= 1'b0;
      a_raw <= '0;
      d     <= '0;
      q     <= '0;
      r     <= '0;
      cnt   <= '0;
    end else if (accept) begin
      op_r  <= m.op;
      sa    <= sa_in;
      sb    <= sb_in;
      bz    <= m.src_b == '0;
      a_raw <= m.src_a;
      d     <= m.op[1] ? mag_b : mag_a;
      q     <= m.op[1] ? mag_a : mag_b;
      r     <= '0;
      cnt   <= '0;
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      r   <= op_r[1] ? (dneg ? dsh : dsub) : {1'b0, msum[WIDTH:1]};
      q   <= op_r[1] ? {q[WIDTH-2:0], ~dneg} : {msum[0], q[WIDTH-1:1]};
    end
  always_comb begin
    prod   = {r[WIDTH-1:0], q};
    prod_s = (sa ^ sb) ? -prod : prod;
    quo    = (sa ^ sb) ? -q : q;
    rem    = sa ? -r[WIDTH-1:0] : r[WIDTH-1:0];
    res_hi = !op_r[1] ? prod_s[2*WIDTH-1:WIDTH] : bz ? a_raw : rem;
    res_lo = !op_r[1] ? prod_s[WIDTH-1:0] : bz ? '1 : quo;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m.busy        <= 1'b0;
      m.done        <= 1'b0;
      m.hi          <= '0;
      m.lo          <= '0;
      m.div_by_zero <= 1'b0;
    end else begin
      m.busy <= busy_nx;
      m.done <= done_nx;
      if (done_nx) begin
        m.hi          <= res_hi;
        m.lo          <= res_lo;
        m.div_by_zero <= op_r[1] & bz;
      end
`ifdef MDU_MTHILO_EN
      else if (state == IDLE && !accept) begin
        if (m.hilo_we[1]) m.hi <= m.hilo_wdata;
        if (m.hilo_we[0]) m.lo <= m.hilo_wdata;
      end
`endif
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors for mult_div_unit with hand-computed results.
// Define MDU_MTHILO_EN to also exercise the direct HI/LO write path.
module tb_mult_div_unit;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int passed = 0;
  int failed = 0;
  int total = 0;
  int nd;
  mult_div_unit_if #(.WIDTH(W)) bus ();
  mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .m(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz);
    int n, nb;
    bus.start = 1'b1;
    bus.op    = o;
    bus.src_a = a;
    bus.src_b = b;
    tick();
    bus.start = 1'b0;
    nb = int'(bus.busy);
    n  = 0;
    while (!bus.done && n < 40) begin
      tick();
      n++;
      if (bus.busy) nb++;
    end
    chk({tag, "_latency"}, n, W + 1);
    chk({tag, "_busy_cycles"}, nb, W + 1);
    chk({tag, "_hi"}, bus.hi, ehi);
    chk({tag, "_lo"}, bus.lo, elo);
    chk({tag, "_dbz"}, bus.div_by_zero, edbz);
  endtask
  task automatic count_done(input int cycles, output int c);
    c = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.done) c++;
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 2'b00;
    bus.src_a = '0;
    bus.src_b = '0;
`ifdef MDU_MTHILO_EN
    bus.hilo_we    = 2'b00;
    bus.hilo_wdata = '0;
`endif
    #22;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_dbz", bus.div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op("multu_max", 2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0);
    tick();
    chk("done_one_cycle", bus.done, 0);
    chk("hi_hold", bus.hi, 16'hFFFE);
    run_op("mult_neg", 2'b01, 16'hFFFE, 16'h0003, 16'hFFFF, 16'hFFFA, 1'b0);
    run_op("mult_b2b_min", 2'b01, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0);
    run_op("divu_100_7", 2'b10, 16'd100, 16'd7, 16'd2, 16'd14, 1'b0);
    run_op("div_neg", 2'b11, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0);
    run_op("div_ovf", 2'b11, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0);
    run_op("divu_zero", 2'b10, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1);
    run_op("multu_after_dbz", 2'b00, 16'd2, 16'd3, 16'd0, 16'd6, 1'b0);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.src_a = 16'd3;
    bus.src_b = 16'd5;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.start = 1'b1;
    bus.src_a = 16'd7;
    bus.src_b = 16'd7;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 40 && !bus.done; i++) tick();
    chk("busy_ign_done", bus.done, 1);
    chk("busy_ign_lo", bus.lo, 16'd15);
    chk("busy_ign_hi", bus.hi, 16'd0);
    count_done(25, nd);
    chk("busy_ign_one_done", nd, 0);
    bus.start = 1'b1;
    bus.src_a = 16'h1111;
    bus.src_b = 16'h0010;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_busy", bus.busy, 0);
    count_done(25, nd);
    chk("flush_no_done", nd, 0);
    chk("flush_lo_kept", bus.lo, 16'd15);
    chk("flush_hi_kept", bus.hi, 16'd0);
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.src_a = 16'h1234;
    bus.src_b = 16'd5;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_lo", bus.lo, 0);
    chk("midrst_hi", bus.hi, 0);
    chk("midrst_done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(20, nd);
    chk("midrst_no_done", nd, 0);
    run_op("after_rst", 2'b10, 16'h1234, 16'd5, 16'd0, 16'h03A4, 1'b0);
`ifdef MDU_MTHILO_EN
    bus.hilo_we    = 2'b01;
    bus.hilo_wdata = 16'hBEEF;
    tick();
    bus.hilo_we = 2'b00;
    chk("mtlo_idle", bus.lo, 16'hBEEF);
    chk("mtlo_hi_kept", bus.hi, 16'd0);
    bus.hilo_we    = 2'b10;
    bus.hilo_wdata = 16'hCAFE;
    tick();
    bus.hilo_we = 2'b00;
    chk("mthi_idle", bus.hi, 16'hCAFE);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.src_a = 16'd1;
    bus.src_b = 16'd1;
    tick();
    bus.start      = 1'b0;
    bus.hilo_we    = 2'b11;
    bus.hilo_wdata = 16'h1234;
    tick();
    bus.hilo_we = 2'b00;
    chk("mtlo_busy_drop", bus.lo, 16'hBEEF);
    chk("mthi_busy_drop", bus.hi, 16'hCAFE);
    for (int i = 0; i < 40 && !bus.done; i++) tick();
    chk("mthilo_op_lo", bus.lo, 16'd1);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
